// File: rtl/piso_sched_pkg.sv
// piso_sched_pkg: shared state encoding and widths for the two-requester PISO scheduler
package piso_sched_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} sched_state_e;
  localparam int NBITS = 8;
  localparam int CNT_W = 3;
endpackage

// File: rtl/piso_sched_2req_sreg.sv
// piso_sreg_8b: 8-bit parallel-in/serial-out shift register, load beats shift, MSB out
module piso_sreg_8b
  import piso_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ld,
  input  logic [NBITS-1:0] pin,
  output logic             sout
);
  logic [NBITS-1:0] sr_q;
  always_ff @(posedge clk)
    if (reset) sr_q <= '0;
    else if (ld) sr_q <= pin;
    else if (en) sr_q <= {sr_q[NBITS-2:0], 1'b0};
  assign sout = sr_q[NBITS-1];
endmodule

// File: rtl/piso_sched_2req.sv
// piso_sched_2req: round-robin two-requester scheduler streaming bytes MSB-first over one serial link
// Optional even-parity trailer bit enabled by defining PISO_SCHED_PARITY_EN.
module piso_sched_2req #(
  parameter int GAP = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_val,
  output logic                          req0_rdy,
  input  logic [piso_sched_pkg::NBITS-1:0] req0_data,
  input  logic                          req1_val,
  output logic                          req1_rdy,
  input  logic [piso_sched_pkg::NBITS-1:0] req1_data,
  output logic                          sout,
  output logic                          sout_val,
  output logic                          sout_src,
  output logic                          busy
);
  import piso_sched_pkg::*;
  sched_state_e     state_q, post_s;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       gcnt_q;
  logic             ptr_q, src_q, gnt, fire, idle, msb;
  logic [NBITS-1:0] pin;
`ifdef PISO_SCHED_PARITY_EN
  logic             par_q;
`endif
  always_comb begin
    idle     = state_q == IDLE;
    gnt      = req1_val & (~req0_val | ptr_q);
    req0_rdy = idle & ~reset & req0_val & ~gnt;
    req1_rdy = idle & ~reset & gnt;
    fire     = req0_rdy | req1_rdy;
    pin      = gnt ? req1_data : req0_data;
    post_s   = IDLE;
    if (GAP > 0) post_s = piso_sched_pkg::GAP;
  end
  piso_sreg_8b u_sreg (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == SHIFT),
    .ld   (fire),
    .pin  (pin),
    .sout (msb)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      ptr_q   <= 1'b0;
      src_q   <= 1'b0;
`ifdef PISO_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (fire) begin
          state_q <= SHIFT;
          cnt_q   <= '0;
          ptr_q   <= ~gnt;
          src_q   <= gnt;
`ifdef PISO_SCHED_PARITY_EN
          par_q   <= ^pin;
`endif
        end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
`ifdef PISO_SCHED_PARITY_EN
          if (cnt_q == CNT_W'(NBITS - 1)) state_q <= PAR;
`else
          if (cnt_q == CNT_W'(NBITS - 1)) state_q <= post_s;
`endif
        end
`ifdef PISO_SCHED_PARITY_EN
        PAR: state_q <= post_s;
`endif
        default: begin
          gcnt_q <= gcnt_q + 1'b1;
          if (gcnt_q == 4'(GAP - 1)) begin
            gcnt_q  <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  assign sout_val = (state_q == SHIFT) | (state_q == PAR);
`ifdef PISO_SCHED_PARITY_EN
  assign sout     = (state_q == PAR) ? par_q : ((state_q == SHIFT) & msb);
`else
  assign sout     = (state_q == SHIFT) & msb;
`endif
  assign sout_src = src_q;
  assign busy     = ~idle;
endmodule

// File: tb/tb_piso_sched_2req.sv
// tb_piso_sched_2req: randomized bench against a frame-phase reference model
module tb_piso_sched_2req;
  localparam int G = 3;
`ifdef PISO_SCHED_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif
  logic clk = 1'b0;
  logic reset, req0_val, req1_val, req0_rdy, req1_rdy, sout, sout_val, sout_src, busy;
  logic [7:0] req0_data, req1_data;
  int n_chk = 0, n_err = 0, cyc = 0;
  int ph = 0;
  bit ptr = 0, src = 0, did_rst = 0, gv, g, e_r0, e_r1, e_val, e_out;
  logic [7:0] d = '0;

  piso_sched_2req #(.GAP(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0_val (req0_val),
    .req0_rdy (req0_rdy),
    .req0_data(req0_data),
    .req1_val (req1_val),
    .req1_rdy (req1_rdy),
    .req1_data(req1_data),
    .sout     (sout),
    .sout_val (sout_val),
    .sout_src (sout_src),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    req0_data = '0;
    req1_data = '0;
    @(posedge clk);
    for (cyc = 0; cyc < 3000; cyc++) begin
      #1;
      reset = (cyc < 2) || (cyc >= 100 && $urandom_range(0, 99) == 0);
      if (cyc >= 30 && !did_rst && ph == 5) begin
        reset = 1'b1;
        did_rst = 1'b1;
      end
      if (cyc < 20) begin
        req0_val = 1'b1; req0_data = 8'hA5;
        req1_val = 1'b0; req1_data = 8'($urandom);
      end else if (cyc < 80) begin
        req0_val = 1'b1; req0_data = 8'hFF;
        req1_val = 1'b1; req1_data = 8'h00;
      end else begin
        req0_val = $urandom_range(0, 2) != 0; req0_data = 8'($urandom);
        req1_val = $urandom_range(0, 2) != 0; req1_data = 8'($urandom);
      end
      #3;
      gv    = !reset && ph == 0 && (req0_val || req1_val);
      g     = (req0_val && req1_val) ? ptr : req1_val;
      e_r0  = gv && !g;
      e_r1  = gv && g;
      e_val = ph >= 1 && ph <= L;
      e_out = e_val && ((ph <= 8) ? d[8-ph] : ^d);
      chk("req0_rdy", req0_rdy, e_r0);
      chk("req1_rdy", req1_rdy, e_r1);
      chk("sout_val", sout_val, e_val);
      chk("sout", sout, e_out);
      chk("sout_src", sout_src, src);
      chk("busy", busy, ph != 0);
      if (reset) begin
        ph = 0; ptr = 0; src = 0;
      end else if (gv) begin
        ph = 1; d = g ? req1_data : req0_data; src = g; ptr = !g;
      end else if (ph != 0) begin
        ph = (ph == L + G) ? 0 : ph + 1;
      end
      @(posedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
